// File: rtl/burst_ram_pkg.sv
// Shared types and helpers for the burst RAM: clear-sequencer states,
// byte counting and the byte-enable merge used by the write and forwarding paths.
package burst_ram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } clrState_e;

    localparam int BITS_PER_BYTE = 8;

    function automatic int byteCount(input int dataWidth);
        return dataWidth / BITS_PER_BYTE;
    endfunction

    // One byte of the merge; callers loop over the byte lanes of a word.
    function automatic logic [7:0] mergeByte(
        input logic [7:0] oldByte,
        input logic [7:0] newByte,
        input logic       en
    );
        return en ? newByte : oldByte;
    endfunction

endpackage

// File: rtl/burst_ram_clear_fsm.sv
// Clear sequencer: sweeps every address once after reset or on request,
// and reports busy while the sweep is in progress.
module burst_ram_clear_fsm
    import burst_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
)
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clrReq_i,
    output logic                  busy_o,
    output logic                  clrWe_o,
    output logic [ADDR_WIDTH-1:0] clrAddr_o
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    clrState_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  busy_q, busy_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            CLEAR: begin
                cnt_d = cnt_q + ADDR_WIDTH'(1);
                if (cnt_q == LAST_ADDR) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (clrReq_i) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            default: state_d = CLEAR;
        endcase
        busy_d = (state_d == CLEAR);
    end

    // The array must stay untouched during a reset edge, even mid-sweep.
    assign busy_o    = busy_q;
    assign clrWe_o   = (state_q == CLEAR) && !rst_i;
    assign clrAddr_o = cnt_q;

endmodule

// File: rtl/burst_ram.sv
// Multi-lane burst RAM: byte-enabled write port, LANES-word registered read
// bursts with wrapping addresses, optional write forwarding and a clear sweep.
module burst_ram
    import burst_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int LANES      = 4,
    parameter bit WR_FWD     = 1'b1
)
(
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          we_i,
    input  logic [ADDR_WIDTH-1:0]         wrAddr_i,
    input  logic [DATA_WIDTH-1:0]         wrData_i,
    input  logic [DATA_WIDTH/8-1:0]       wrBe_i,
    input  logic                          rdReq_i,
    input  logic [ADDR_WIDTH-1:0]         rdAddr_i,
    output logic [LANES*DATA_WIDTH-1:0]   rdData_o,
    output logic                          rdValid_o,
    input  logic                          clrReq_i,
    output logic                          busy_o
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int BYTES = byteCount(DATA_WIDTH);

    logic [DATA_WIDTH-1:0]       mem [DEPTH];

    logic                        busy;
    logic                        clrWe;
    logic [ADDR_WIDTH-1:0]       clrAddr;
    logic                        userWe;
    logic                        userRd;
    logic [DATA_WIDTH-1:0]       wrMerged;
    logic [ADDR_WIDTH-1:0]       laneAddr;
    logic [DATA_WIDTH-1:0]       laneWord;
    logic [LANES*DATA_WIDTH-1:0] rdData_q, rdData_d;
    logic                        rdValid_q, rdValid_d;

    burst_ram_clear_fsm #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) uClearFsm (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clrReq_i  (clrReq_i),
        .busy_o    (busy),
        .clrWe_o   (clrWe),
        .clrAddr_o (clrAddr)
    );

    // A clear request in IDLE wins over any same-cycle user access.
    assign userWe = we_i    && !busy && !clrReq_i && !rst_i;
    assign userRd = rdReq_i && !busy && !clrReq_i && !rst_i;

    always_comb begin
        wrMerged = mem[wrAddr_i];
        for (int b = 0; b < BYTES; b++) begin
            wrMerged[b*8 +: 8] = mergeByte(mem[wrAddr_i][b*8 +: 8],
                                           wrData_i[b*8 +: 8],
                                           wrBe_i[b]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (clrWe) begin
            mem[clrAddr] <= '0;
        end else if (userWe) begin
            mem[wrAddr_i] <= wrMerged;
        end
    end

    // Lane addresses truncate to ADDR_WIDTH bits, which gives the modulo-DEPTH wrap.
    always_comb begin
        rdData_d  = rdData_q;
        rdValid_d = userRd;
        laneAddr  = '0;
        laneWord  = '0;
        if (userRd) begin
            for (int k = 0; k < LANES; k++) begin
                laneAddr = rdAddr_i + ADDR_WIDTH'(k);
                laneWord = mem[laneAddr];
                if (WR_FWD && userWe && (wrAddr_i == laneAddr)) begin
                    laneWord = wrMerged;
                end
                rdData_d[k*DATA_WIDTH +: DATA_WIDTH] = laneWord;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdData_q  <= '0;
            rdValid_q <= 1'b0;
        end else begin
            rdData_q  <= rdData_d;
            rdValid_q <= rdValid_d;
        end
    end

    assign rdData_o  = rdData_q;
    assign rdValid_o = rdValid_q;
    assign busy_o    = busy;

endmodule

// File: tb/tb_burst_ram.sv
// Directed bench for burst_ram: one forwarding and one non-forwarding instance
// share the same stimulus so collision behaviour is compared side by side.
`timescale 1ns/1ps
module tb_burst_ram;

    logic         clk;
    logic         rst;
    logic         we;
    logic [7:0]   wrAddr;
    logic [31:0]  wrData;
    logic [3:0]   wrBe;
    logic         rdReq;
    logic [7:0]   rdAddr;
    logic         clrReq;

    logic [127:0] rdDataF, rdDataN;
    logic         rdValidF, rdValidN;
    logic         busyF, busyN;

    int passCount  = 0;
    int totalCount = 0;
    int busyCycles;
    int strayValid;

    burst_ram #(
        .ADDR_WIDTH (8),
        .DATA_WIDTH (32),
        .LANES      (4),
        .WR_FWD     (1'b1)
    ) dutFwd (
        .clk_i     (clk),
        .rst_i     (rst),
        .we_i      (we),
        .wrAddr_i  (wrAddr),
        .wrData_i  (wrData),
        .wrBe_i    (wrBe),
        .rdReq_i   (rdReq),
        .rdAddr_i  (rdAddr),
        .rdData_o  (rdDataF),
        .rdValid_o (rdValidF),
        .clrReq_i  (clrReq),
        .busy_o    (busyF)
    );

    burst_ram #(
        .ADDR_WIDTH (8),
        .DATA_WIDTH (32),
        .LANES      (4),
        .WR_FWD     (1'b0)
    ) dutNoFwd (
        .clk_i     (clk),
        .rst_i     (rst),
        .we_i      (we),
        .wrAddr_i  (wrAddr),
        .wrData_i  (wrData),
        .wrBe_i    (wrBe),
        .rdReq_i   (rdReq),
        .rdAddr_i  (rdAddr),
        .rdData_o  (rdDataN),
        .rdValid_o (rdValidN),
        .clrReq_i  (clrReq),
        .busy_o    (busyN)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Outputs are sampled 1ns after the edge that produced them.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(
        input logic        weV,
        input logic [7:0]  wa,
        input logic [31:0] wd,
        input logic [3:0]  be,
        input logic        rq,
        input logic [7:0]  ra,
        input logic        cq
    );
        we     = weV;
        wrAddr = wa;
        wrData = wd;
        wrBe   = be;
        rdReq  = rq;
        rdAddr = ra;
        clrReq = cq;
        tick();
        we     = 1'b0;
        rdReq  = 1'b0;
        clrReq = 1'b0;
    endtask

    task automatic checkOutput(
        input string        tag,
        input logic [127:0] observed,
        input logic [127:0] expected
    );
        totalCount++;
        assert (observed === expected) passCount++;
        else begin
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
            $error("[TB] %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Keeps hammering writes/reads while busy, counting busy cycles and any stray valid.
    task automatic waitClear();
        busyCycles = 0;
        strayValid = 0;
        we     = 1'b1;
        wrAddr = 8'd4;
        wrData = 32'hDEADBEEF;
        wrBe   = 4'hF;
        rdReq  = 1'b1;
        rdAddr = 8'd0;
        while (busyF && busyCycles < 1000) begin
            busyCycles++;
            if (rdValidF || rdValidN) strayValid++;
            tick();
        end
        we    = 1'b0;
        rdReq = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst = 1'b1; we = 1'b0; wrAddr = '0; wrData = '0; wrBe = '0;
        rdReq = 1'b0; rdAddr = '0; clrReq = 1'b0;

        tick();
        checkOutput("resetValid", 128'(rdValidF), 128'(1'b0));
        checkOutput("resetData", rdDataF, 128'h0);
        checkOutput("resetBusyF", 128'(busyF), 128'(1'b1));
        checkOutput("resetBusyN", 128'(busyN), 128'(1'b1));
        tick();
        rst = 1'b0;

        waitClear();
        checkOutput("initClearCycles", 128'(busyCycles), 128'(256));
        checkOutput("initClearStray", 128'(strayValid), 128'(0));
        checkOutput("initClearBusyN", 128'(busyN), 128'(1'b0));
        checkOutput("initClearValid", 128'(rdValidF), 128'(1'b0));

        applyStimulus(1'b0, 8'd0, 32'h0, 4'h0, 1'b1, 8'd0, 1'b0);
        checkOutput("zeroReadValid", 128'(rdValidF), 128'(1'b1));
        checkOutput("zeroReadData", rdDataF, 128'h0);

        applyStimulus(1'b1, 8'd10, 32'hA0, 4'hF, 1'b0, 8'd0, 1'b0);
        applyStimulus(1'b1, 8'd11, 32'hA1, 4'hF, 1'b0, 8'd0, 1'b0);
        applyStimulus(1'b1, 8'd12, 32'hA2, 4'hF, 1'b0, 8'd0, 1'b0);
        applyStimulus(1'b1, 8'd13, 32'hA3, 4'hF, 1'b0, 8'd0, 1'b0);
        checkOutput("writeNoValid", 128'(rdValidF), 128'(1'b0));
        applyStimulus(1'b0, 8'd0, 32'h0, 4'h0, 1'b1, 8'd10, 1'b0);
        checkOutput("burstValid", 128'(rdValidF), 128'(1'b1));
        checkOutput("burstDataF", rdDataF, 128'h000000A3_000000A2_000000A1_000000A0);
        checkOutput("burstDataN", rdDataN, 128'h000000A3_000000A2_000000A1_000000A0);
        applyStimulus(1'b0, 8'd0, 32'h0, 4'h0, 1'b0, 8'd0, 1'b0);
        checkOutput("validPulse", 128'(rdValidF), 128'(1'b0));
        checkOutput("dataHold", rdDataF, 128'h000000A3_000000A2_000000A1_000000A0);

        applyStimulus(1'b1, 8'd10, 32'hFFFFFFFF, 4'h0, 1'b0, 8'd0, 1'b0);
        applyStimulus(1'b0, 8'd0, 32'h0, 4'h0, 1'b1, 8'd10, 1'b0);
        checkOutput("beZeroNoop", 128'(rdDataF[31:0]), 128'(32'hA0));

        applyStimulus(1'b1, 8'd5, 32'h11223344, 4'hF, 1'b0, 8'd0, 1'b0);
        applyStimulus(1'b1, 8'd5, 32'hAABBCCDD, 4'b0101, 1'b0, 8'd0, 1'b0);
        applyStimulus(1'b0, 8'd0, 32'h0, 4'h0, 1'b1, 8'd5, 1'b0);
        checkOutput("byteMerge", 128'(rdDataF[31:0]), 128'(32'h11BB33DD));

        applyStimulus(1'b1, 8'd254, 32'h1, 4'hF, 1'b0, 8'd0, 1'b0);
        applyStimulus(1'b1, 8'd255, 32'h2, 4'hF, 1'b0, 8'd0, 1'b0);
        applyStimulus(1'b1, 8'd0,   32'h3, 4'hF, 1'b0, 8'd0, 1'b0);
        applyStimulus(1'b1, 8'd1,   32'h4, 4'hF, 1'b0, 8'd0, 1'b0);
        applyStimulus(1'b0, 8'd0, 32'h0, 4'h0, 1'b1, 8'd254, 1'b0);
        checkOutput("wrapDataF", rdDataF, 128'h00000004_00000003_00000002_00000001);
        checkOutput("wrapDataN", rdDataN, 128'h00000004_00000003_00000002_00000001);

        applyStimulus(1'b1, 8'd20, 32'h0, 4'hF, 1'b0, 8'd0, 1'b0);
        applyStimulus(1'b1, 8'd20, 32'hFFFF0000, 4'hF, 1'b1, 8'd18, 1'b0);
        checkOutput("collideValidN", 128'(rdValidN), 128'(1'b1));
        checkOutput("collideFwd", 128'(rdDataF[64 +: 32]), 128'(32'hFFFF0000));
        checkOutput("collideNoFwd", 128'(rdDataN[64 +: 32]), 128'(32'h0));
        applyStimulus(1'b0, 8'd0, 32'h0, 4'h0, 1'b1, 8'd20, 1'b0);
        checkOutput("backToBackValid", 128'(rdValidF), 128'(1'b1));
        checkOutput("afterCollideF", 128'(rdDataF[31:0]), 128'(32'hFFFF0000));
        checkOutput("afterCollideN", 128'(rdDataN[31:0]), 128'(32'hFFFF0000));

        applyStimulus(1'b1, 8'd3, 32'h77, 4'hF, 1'b0, 8'd0, 1'b0);
        applyStimulus(1'b1, 8'd3, 32'h55, 4'hF, 1'b1, 8'd3, 1'b1);
        checkOutput("clrDropsRead", 128'(rdValidF), 128'(1'b0));
        checkOutput("clrBusy", 128'(busyF), 128'(1'b1));
        checkOutput("clrDataHold", rdDataF, 128'h00000000_00000000_00000000_FFFF0000);
        for (int i = 0; i < 99; i++) begin
            tick();
        end
        checkOutput("midClearBusy", 128'(busyF), 128'(1'b1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("midResetData", rdDataF, 128'h0);
        checkOutput("midResetBusy", 128'(busyF), 128'(1'b1));
        waitClear();
        checkOutput("midResetCycles", 128'(busyCycles), 128'(256));
        checkOutput("midResetStray", 128'(strayValid), 128'(0));

        applyStimulus(1'b0, 8'd0, 32'h0, 4'h0, 1'b1, 8'd3, 1'b0);
        checkOutput("postClearValid", 128'(rdValidF), 128'(1'b1));
        checkOutput("postClearDataF", rdDataF, 128'h0);
        checkOutput("postClearDataN", rdDataN, 128'h0);

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
